// File: rtl/nf_i_fu_if.sv
// Fetch-unit bus bundle: instruction-memory request/ack side plus decode-side handshake.
// Latency: none (wiring only).
// Backpressure: stall_if from decode holds delivery; ack_i from memory completes a request.
interface nf_i_fu_if;
    // Instruction memory side
    logic [31:0] addr_i;
    logic        req_i;
    logic        ack_i;
    logic [31:0] rd_i;
    // Decode side
    logic [31:0] instr_id;
    logic [31:0] pc_id;
    logic        valid_id;
    logic        stall_if;
    logic        flush_id;
    logic        pc_src;
    logic [31:0] pc_branch;

    // Fetch unit view
    modport master (
        output addr_i, req_i, instr_id, pc_id, valid_id,
        input  ack_i, rd_i, stall_if, flush_id, pc_src, pc_branch
    );

    // Memory / decode environment view
    modport slave (
        input  addr_i, req_i, instr_id, pc_id, valid_id,
        output ack_i, rd_i, stall_if, flush_id, pc_src, pc_branch
    );
endinterface

// File: rtl/nf_i_fu.sv
// Instruction fetch unit: owns the PC, one outstanding imem request, one-entry skid, redirect/flush.
// Latency: ack in cycle N -> registered instr_id/pc_id valid in cycle N+1.
// Backpressure: stall_if parks an acked word in the skid and drops req_i until released.
// Optional feature macro NF_IFU_MISALIGN_EN adds misalign_err (one-cycle pulse on a misaligned redirect).
module nf_i_fu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BUBBLE   = 32'h0000_0013
) (
    input  logic      clk,
    input  logic      resetn,
    nf_i_fu_if.master bus
`ifdef NF_IFU_MISALIGN_EN
    ,output logic     misalign_err
`endif
);

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc_if;
    logic [31:0] r_addr;
    logic        r_req;
    logic [31:0] r_instr;
    logic [31:0] r_pc_id;
    logic        r_valid;
    logic [31:0] r_skid_dat;
    logic [31:0] r_skid_pc;
    logic        r_skid_vld;

    // An ack only counts while a request is actually being driven.
    logic        w_ack;
    logic [31:0] w_tgt;
    logic [31:0] w_pc_inc;
    logic [31:0] w_disc_pc;

    assign w_ack     = bus.ack_i & r_req;
    assign w_tgt     = bus.pc_branch & ~32'h0000_0003;
    assign w_pc_inc  = r_pc_if + 32'd4;
    assign w_disc_pc = bus.pc_src ? w_tgt : r_pc_if;

    assign bus.addr_i   = r_addr;
    assign bus.req_i    = r_req;
    assign bus.instr_id = r_instr;
    assign bus.pc_id    = r_pc_id;
    assign bus.valid_id = r_valid;

    // Fetch FSM: PC/address sequencing, skid handling and registered decode outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_REQ;
            r_pc_if    <= RESET_PC;
            r_addr     <= RESET_PC;
            r_req      <= 1'b0;
            r_instr    <= BUBBLE;
            r_pc_id    <= RESET_PC;
            r_valid    <= 1'b0;
            r_skid_dat <= 32'd0;
            r_skid_pc  <= 32'd0;
            r_skid_vld <= 1'b0;
        end else begin
            case (r_state)
                ST_REQ: begin
                    r_req <= 1'b1;
                    if (bus.pc_src) begin
                        // Redirect: never deliver this cycle's data; an un-acked
                        // request must be allowed to complete with the old address.
                        r_pc_if <= w_tgt;
                        if (w_ack) begin
                            r_addr <= w_tgt;
                        end else begin
                            r_state <= ST_DISCARD;
                        end
                    end else if (w_ack) begin
                        r_pc_if <= w_pc_inc;
                        r_addr  <= w_pc_inc;
                        if (bus.flush_id) begin
                            // Flushed ack word is dropped; fetch continues sequentially.
                        end else if (bus.stall_if) begin
                            r_skid_dat <= bus.rd_i;
                            r_skid_pc  <= r_pc_if;
                            r_skid_vld <= 1'b1;
                            r_req      <= 1'b0;
                            r_state    <= ST_HOLD;
                        end else begin
                            r_instr <= bus.rd_i;
                            r_pc_id <= r_pc_if;
                            r_valid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.pc_src) begin
                        r_skid_vld <= 1'b0;
                        r_pc_if    <= w_tgt;
                        r_addr     <= w_tgt;
                        r_req      <= 1'b1;
                        r_state    <= ST_REQ;
                    end else if (!bus.stall_if) begin
                        if (!bus.flush_id && r_skid_vld) begin
                            r_instr <= r_skid_dat;
                            r_pc_id <= r_skid_pc;
                            r_valid <= 1'b1;
                        end
                        r_skid_vld <= 1'b0;
                        r_req      <= 1'b1;
                        r_state    <= ST_REQ;
                    end
                end
                ST_DISCARD: begin
                    // Old address stays on the bus until its ack, whose data is dropped.
                    r_req   <= 1'b1;
                    r_pc_if <= w_disc_pc;
                    if (w_ack) begin
                        r_addr  <= w_disc_pc;
                        r_state <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_REQ;
                end
            endcase

            // Flush wins over any delivery made above in the same cycle.
            if (bus.flush_id) begin
                r_instr <= BUBBLE;
                r_valid <= 1'b0;
            end
        end
    end

`ifdef NF_IFU_MISALIGN_EN
    logic r_misalign;
    assign misalign_err = r_misalign;

    // Flag a redirect whose target had non-zero low bits, one cycle later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= bus.pc_src & (|bus.pc_branch[1:0]);
        end
    end
`endif

endmodule

// File: tb/tb_nf_i_fu.sv
// Directed bench for nf_i_fu with a delivery scoreboard.
// Latency: expects decode data one cycle after each accepted ack.
// Backpressure: exercises stall/skid, flush and redirect paths.
module tb_nf_i_fu;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    nf_i_fu_if bus_if();

`ifdef NF_IFU_MISALIGN_EN
    logic misalign_err;
`endif

    nf_i_fu dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
`ifdef NF_IFU_MISALIGN_EN
        ,.misalign_err (misalign_err)
`endif
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    logic        mon_last_vld = 1'b0;
    logic [31:0] mon_last_pc  = 32'd0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {8'hAB, a[23:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of inputs at the negedge, then advance to the next negedge.
    task automatic drv(input logic ack, input logic stall, input logic flush,
                       input logic src, input logic [31:0] br, input logic [31:0] rd);
        bus_if.ack_i     = ack;
        bus_if.stall_if  = stall;
        bus_if.flush_id  = flush;
        bus_if.pc_src    = src;
        bus_if.pc_branch = br;
        bus_if.rd_i      = rd;
        @(negedge clk);
    endtask

    // Delivery monitor: each new valid instr/pc pair must match the scoreboard head.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus_if.valid_id && (!mon_last_vld || bus_if.pc_id != mon_last_pc)) begin
                n_tests++;
                assert (sb_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_unexpected observed pc=0x%08h expected=none", bus_if.pc_id);
                end
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_instr", bus_if.instr_id, e.instr);
                    chk("sb_pc", bus_if.pc_id, e.pc);
                end
            end
            mon_last_vld = bus_if.valid_id;
            mon_last_pc  = bus_if.pc_id;
        end
    end

    initial begin
        bus_if.ack_i     = 1'b0;
        bus_if.rd_i      = 32'd0;
        bus_if.stall_if  = 1'b0;
        bus_if.flush_id  = 1'b0;
        bus_if.pc_src    = 1'b0;
        bus_if.pc_branch = 32'd0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_addr", bus_if.addr_i, 32'h0);
        chk("rst_req", {31'd0, bus_if.req_i}, 32'd0);
        chk("rst_instr", bus_if.instr_id, 32'h0000_0013);
        chk("rst_pc_id", bus_if.pc_id, 32'h0);
        chk("rst_valid", {31'd0, bus_if.valid_id}, 32'd0);
`ifdef NF_IFU_MISALIGN_EN
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
`endif
        resetn = 1'b1;
        @(negedge clk);

        // Back-to-back acks: one instruction per cycle
        chk("t1_req", {31'd0, bus_if.req_i}, 32'd1);
        chk("t1_addr0", bus_if.addr_i, 32'h0);
        push(memw(32'h0), 32'h0);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, memw(32'h0));
        chk("t1_addr4", bus_if.addr_i, 32'h4);
        chk("t1_valid", {31'd0, bus_if.valid_id}, 32'd1);
        push(memw(32'h4), 32'h4);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, memw(32'h4));
        chk("t1_addr8", bus_if.addr_i, 32'h8);
        push(memw(32'h8), 32'h8);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, memw(32'h8));
        chk("t1_addrC", bus_if.addr_i, 32'hC);
        push(memw(32'hC), 32'hC);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, memw(32'hC));

        // Ack delayed three cycles: address held, decode unchanged
        for (int i = 0; i < 3; i++) begin
            chk("t2_addr_hold", bus_if.addr_i, 32'h10);
            chk("t2_instr_hold", bus_if.instr_id, memw(32'hC));
            drv(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        push(memw(32'h10), 32'h10);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, memw(32'h10));
        chk("t2_addr14", bus_if.addr_i, 32'h14);
        chk("t2_instr", bus_if.instr_id, memw(32'h10));

        // Stall for four cycles with the ack landing in the first
        push(32'h0050_0093, 32'h14);
        drv(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0050_0093);
        chk("t3_req_drop", {31'd0, bus_if.req_i}, 32'd0);
        chk("t3_instr_keep", bus_if.instr_id, memw(32'h10));
        chk("t3_pc_keep", bus_if.pc_id, 32'h10);
        drv(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("t3_req_drop2", {31'd0, bus_if.req_i}, 32'd0);
        drv(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        drv(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("t3_instr_keep2", bus_if.instr_id, memw(32'h10));
        drv(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("t3_instr_skid", bus_if.instr_id, 32'h0050_0093);
        chk("t3_req_resume", {31'd0, bus_if.req_i}, 32'd1);
        chk("t3_addr18", bus_if.addr_i, 32'h18);

        // Redirect with an un-acked request outstanding (plus flush)
        drv(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'd0);
        chk("t4_addr_old", bus_if.addr_i, 32'h18);
        chk("t4_req", {31'd0, bus_if.req_i}, 32'd1);
        chk("t4_valid0", {31'd0, bus_if.valid_id}, 32'd0);
        chk("t4_bubble", bus_if.instr_id, 32'h0000_0013);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, memw(32'h18));
        chk("t4_addr_tgt", bus_if.addr_i, 32'h100);
        chk("t4_dropped", {31'd0, bus_if.valid_id}, 32'd0);
        push(memw(32'h100), 32'h100);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, memw(32'h100));
        chk("t4_addr104", bus_if.addr_i, 32'h104);
        chk("t4_pc100", bus_if.pc_id, 32'h100);

        // Flush together with an ack: word dropped, bubble presented
        drv(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, memw(32'h104));
        chk("t5_bubble", bus_if.instr_id, 32'h0000_0013);
        chk("t5_valid0", {31'd0, bus_if.valid_id}, 32'd0);
        chk("t5_pc_keep", bus_if.pc_id, 32'h100);
        chk("t5_addr108", bus_if.addr_i, 32'h108);

        // Misaligned redirect coinciding with an ack
        drv(1'b1, 1'b0, 1'b0, 1'b1, 32'h203, memw(32'h108));
        chk("t6_addr_align", bus_if.addr_i, 32'h200);
        chk("t6_req", {31'd0, bus_if.req_i}, 32'd1);
        chk("t6_valid0", {31'd0, bus_if.valid_id}, 32'd0);
`ifdef NF_IFU_MISALIGN_EN
        chk("t6_misalign_hi", {31'd0, misalign_err}, 32'd1);
`endif
        drv(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
`ifdef NF_IFU_MISALIGN_EN
        chk("t6_misalign_lo", {31'd0, misalign_err}, 32'd0);
`endif
        chk("t6_addr_hold", bus_if.addr_i, 32'h200);

        // Redirect while holding a skid word: skid discarded
        drv(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, memw(32'h200));
        chk("t7_req_drop", {31'd0, bus_if.req_i}, 32'd0);
        drv(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'd0);
        chk("t7_req", {31'd0, bus_if.req_i}, 32'd1);
        chk("t7_addr300", bus_if.addr_i, 32'h300);
        chk("t7_valid0", {31'd0, bus_if.valid_id}, 32'd0);
        push(memw(32'h300), 32'h300);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, memw(32'h300));
        chk("t7_addr304", bus_if.addr_i, 32'h304);

        // PC wrap at the top of the address space
        drv(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, memw(32'h304));
        chk("t8_addr_top", bus_if.addr_i, 32'hFFFF_FFFC);
        push(memw(32'hFFFF_FFFC), 32'hFFFF_FFFC);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, memw(32'hFFFF_FFFC));
        chk("t8_addr_wrap", bus_if.addr_i, 32'h0);
        chk("t8_pc_top", bus_if.pc_id, 32'hFFFF_FFFC);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("sb_drained", sb_q.size(), 32'd0);

        // Asynchronous reset between clock edges
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_req", {31'd0, bus_if.req_i}, 32'd0);
        chk("arst_addr", bus_if.addr_i, 32'h0);
        chk("arst_valid", {31'd0, bus_if.valid_id}, 32'd0);
        chk("arst_instr", bus_if.instr_id, 32'h0000_0013);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nf_i_fu.md
Name: nf_i_fu

Overview:
Instruction fetch unit; sits directly upstream of the instruction decode stage.
- Owns the program counter and drives the instruction-memory request/ack interface.
- Delivers a registered instruction/PC pair to decode, with stall, flush and branch redirect.
- Allows one outstanding request; a one-entry skid buffer absorbs data that returns while decode is stalled.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
BUBBLE, 32'h0000_0013, instruction word driven to decode on reset/flush (addi x0,x0,0)

Ports:
clk  input  1  core clock
resetn  input  1  reset, asynchronous, active-low
addr_i  output  32  instruction memory address, word aligned
req_i  output  1  instruction memory request
ack_i  input  1  memory ack; rd_i valid in the same cycle
rd_i  input  32  instruction read data
instr_id  output  32  instruction to decode
pc_id  output  32  PC of instr_id
valid_id  output  1  instr_id holds a real fetched instruction
stall_if  input  1  hold instr_id/pc_id; from hazard unit
flush_id  input  1  replace instr_id with BUBBLE next cycle
pc_src  input  1  redirect request; from decode branch unit
pc_branch  input  32  redirect target

Behaviour:
- Reset (resetn=0, async) values: addr_i=RESET_PC, req_i=0, instr_id=BUBBLE, pc_id=RESET_PC, valid_id=0, state=REQ, pc_if=RESET_PC, skid empty.
- State REQ:
  - req_i=1, addr_i=pc_if. Address is held stable until ack_i.
  - On ack_i with stall_if=0: instr_id<=rd_i, pc_id<=pc_if, valid_id<=1, pc_if<=pc_if+4 (wraps mod 2^32).
  - req_i stays high, so ack every cycle gives 1 instr/cycle. Latency: ack cycle N -> instr_id valid in cycle N+1.
- On ack_i in REQ with stall_if=1:
  - rd_i and pc_if go to the skid buffer; pc_if+=4; go to HOLD.
  - instr_id, pc_id and valid_id are unchanged.
- State HOLD:
  - req_i=0.
  - When stall_if=0: instr_id<=skid, pc_id<=skid pc, valid_id<=1, go to REQ.
- State DISCARD:
  - Entered when pc_src=1 while a request is un-acked in REQ.
  - req_i=1 on the old address, which stays stable; pc_if<=pc_branch.
  - The matching ack data is dropped; go to REQ the cycle after that ack, requesting pc_branch.
- pc_src=1 with ack_i=1 in the same cycle: drop rd_i, pc_if<=pc_branch, stay REQ. The next cycle requests pc_branch.
- pc_src=1 in HOLD: skid cleared, pc_if<=pc_branch, go to REQ.
- pc_src=1 in DISCARD: pc_if<=latest pc_branch; the in-flight data is still dropped.
- Redirect never passes fetched data to decode in the redirect cycle. Redirect overrides stall for PC and state.
- flush_id=1:
  - Next cycle instr_id<=BUBBLE, valid_id<=0, pc_id unchanged.
  - flush beats stall and beats an ack-load in the same cycle; that ack data is discarded.
- stall_if does not block address issue in REQ; only delivery is held.
- pc_branch[1:0] is ignored: the target is forced to {pc_branch[31:2],2'b00}.
- Async reset mid-request abandons the outstanding request. The memory side must tolerate a dropped request.

Optional Feature:
NF_IFU_MISALIGN_EN
- With the macro: extra output port misalign_err (1 bit, reset 0).
  - Pulses for exactly one cycle, the cycle after pc_src=1 with pc_branch[1:0]!=0.
  - The redirect still proceeds to the word-aligned target.
- Without the macro: the port does not exist; low bits are silently cleared.

Test Plan:
- Reset release, ack tied 1 -> req_i=1 from the first cycle; addr_i sequence 0,4,8,C. instr_id follows rd_i one cycle later with pc_id 0,4,8; valid_id=1 from cycle 2.
- ack delayed 3 cycles per request -> addr_i holds 0x0 for 3 cycles, then 0x4. instr_id updates only one cycle after each ack.
- stall_if=1 for 4 cycles, ack arrives in stall cycle 1 (rd_i=0x00500093) -> req_i drops, instr_id unchanged. After stall release instr_id=0x00500093 with the correct pc_id, and req_i resumes at the next PC.
- pc_src=1, pc_branch=0x100 while request to 0x8 is un-acked -> ack data for 0x8 is never presented (valid_id stays low under flush). Next addr_i=0x100.
- flush_id=1 together with ack -> instr_id=0x00000013, valid_id=0; the acked word is dropped.
- With NF_IFU_MISALIGN_EN: pc_src=1, pc_branch=0x102 -> misalign_err pulses 1 cycle; addr_i=0x100.
